float_to_int_2nd: RTL and testbench

// Pipelined IEEE-754 binary32 -> signed INT32 converter; decoding counterpart to the float adder/packing path.

---
 rtl/float_to_int_2nd.sv | 100 ++++++++++
 tb/tb_float_to_int_2nd.sv | 124 ++++++++++++
 2 files changed

// File: rtl/float_to_int_2nd.sv
// float_to_int_2nd: 3-stage pipelined binary32 -> signed int32 converter.
// Round-to-nearest-even, saturates out-of-range/Inf, flags overflow and NaN.
module float_to_int_2nd #(
    parameter int DATA_WIDTH = 32,
    parameter int EXPO_WIDTH = 8,
    parameter int MANT_WIDTH = 23,
    parameter int INT_WIDTH  = 32,
    parameter int BIAS       = 127
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  vld_in,
    input  logic [DATA_WIDTH-1:0] Oprand_A,
    output logic [INT_WIDTH-1:0]  Result,
    output logic                  vld_out,
    output logic                  ovf,
    output logic                  invalid
);
    localparam int XW     = MANT_WIDTH + 1;
    localparam int EXACT_E = BIAS + MANT_WIDTH;
    localparam int SAT_E  = BIAS + INT_WIDTH - 1;
    localparam logic [EXPO_WIDTH-1:0] E_MAX = '1;
    localparam logic [INT_WIDTH-1:0] I_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] I_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

    logic                  w_s;
    logic [EXPO_WIDTH-1:0] w_e;
    logic [MANT_WIDTH-1:0] w_m;
    logic                  w_zero, w_nan, w_sat, w_exact;

    logic                  r0_vld, r0_s, r0_zero, r0_nan, r0_sat, r0_exact;
    logic [EXPO_WIDTH-1:0] r0_e;
    logic [MANT_WIDTH-1:0] r0_m;

    logic [XW-1:0]         w_x;
    logic [2*XW-1:0]       w_t;
    logic [EXPO_WIDTH-1:0] w_lsh, w_rsh;
    logic                  w_big, w_tiny, w_g, w_st;
    logic [INT_WIDTH-1:0]  w_mag;

    logic                  r1_vld, r1_s, r1_zero, r1_nan, r1_sat, r1_exact, r1_g, r1_st;
    logic [INT_WIDTH-1:0]  r1_mag;

    logic [INT_WIDTH-1:0]  w_rnd, w_sgn, w_res;

    always_comb begin
        w_s     = Oprand_A[DATA_WIDTH-1];
        w_e     = Oprand_A[DATA_WIDTH-2 -: EXPO_WIDTH];
        w_m     = Oprand_A[MANT_WIDTH-1:0];
        w_zero  = w_e == '0;
        w_nan   = w_e == E_MAX && w_m != '0;
        w_sat   = w_e >= EXPO_WIDTH'(SAT_E) && !w_nan;
        w_exact = w_s && w_e == EXPO_WIDTH'(SAT_E) && w_m == '0;
    end

    // The 2*XW window keeps the dropped bits so guard/sticky fall out of one shift
    always_comb begin
        w_x    = {1'b1, r0_m};
        w_big  = r0_e >= EXPO_WIDTH'(EXACT_E);
        w_tiny = r0_e < EXPO_WIDTH'(BIAS - 1);
        w_lsh  = r0_e - EXPO_WIDTH'(EXACT_E);
        w_rsh  = EXPO_WIDTH'(EXACT_E) - r0_e;
        w_t    = {w_x, {XW{1'b0}}} >> w_rsh;
        w_mag  = w_big ? INT_WIDTH'(w_x) << w_lsh : INT_WIDTH'(w_t[2*XW-1:XW]);
        w_g    = !w_big && !w_tiny && w_t[XW-1];
        w_st   = w_tiny || (!w_big && |w_t[XW-2:0]);
    end

    always_comb begin
        w_rnd = r1_mag + INT_WIDTH'(r1_g & (r1_st | r1_mag[0]));
        w_sgn = r1_s ? -w_rnd : w_rnd;
        w_res = r1_nan ? I_MAX : r1_sat ? (r1_s ? I_MIN : I_MAX) : r1_zero ? '0 : w_sgn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r0_vld, r0_s, r0_zero, r0_nan, r0_sat, r0_exact} <= '0;
            r0_e     <= '0;
            r0_m     <= '0;
            {r1_vld, r1_s, r1_zero, r1_nan, r1_sat, r1_exact, r1_g, r1_st} <= '0;
            r1_mag   <= '0;
            Result   <= '0;
            vld_out  <= 1'b0;
            ovf      <= 1'b0;
            invalid  <= 1'b0;
        end else if (en) begin
            {r0_vld, r0_s, r0_zero, r0_nan, r0_sat, r0_exact} <= {vld_in, w_s, w_zero, w_nan, w_sat, w_exact};
            r0_e     <= w_e;
            r0_m     <= w_m;
            {r1_vld, r1_s, r1_zero, r1_nan, r1_sat, r1_exact, r1_g, r1_st} <=
                {r0_vld, r0_s, r0_zero, r0_nan, r0_sat, r0_exact, w_g, w_st};
            r1_mag   <= w_mag;
            Result   <= w_res;
            vld_out  <= r1_vld;
            ovf      <= r1_sat && !r1_exact;
            invalid  <= r1_nan;
        end
    end
endmodule

// File: tb/tb_float_to_int_2nd.sv
// tb_float_to_int_2nd: directed-vector self-checking bench for float_to_int_2nd.
module tb_float_to_int_2nd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        vld_in = 1'b0;
    logic [31:0] Oprand_A = '0;
    logic [31:0] Result;
    logic        vld_out, ovf, invalid;
    int          checks = 0;
    int          failures = 0;

    float_to_int_2nd dut (
        .clk(clk), .rst(rst), .en(en), .vld_in(vld_in), .Oprand_A(Oprand_A),
        .Result(Result), .vld_out(vld_out), .ovf(ovf), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic eo, input logic ei);
        check({tag, ".vld"}, {31'b0, vld_out}, 32'd1);
        check({tag, ".res"}, Result, res);
        check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eo});
        check({tag, ".inv"}, {31'b0, invalid}, {31'b0, ei});
    endtask

    task automatic conv(input string tag, input logic [31:0] a, input logic [31:0] res, input logic eo, input logic ei);
        vld_in = 1'b1;
        Oprand_A = a;
        step();
        vld_in = 1'b0;
        check({tag, ".v1"}, {31'b0, vld_out}, 32'd0);
        repeat (2) step();
        check_out(tag, res, eo, ei);
    endtask

    initial begin
        #13;
        check("rst.res", Result, 32'd0);
        check("rst.vld", {31'b0, vld_out}, 32'd0);
        check("rst.flags", {30'b0, ovf, invalid}, 32'd0);
        rst = 1'b0;
        step();

        vld_in = 1'b1;
        Oprand_A = 32'h3FC00000; step();
        Oprand_A = 32'h40200000; step();
        Oprand_A = 32'hC0200000; step();
        vld_in = 1'b0;
        check_out("b2b0", 32'd2, 1'b0, 1'b0);
        step();
        check_out("b2b1", 32'd2, 1'b0, 1'b0);
        step();
        check_out("b2b2", 32'hFFFFFFFE, 1'b0, 1'b0);
        step();
        check("b2b.end", {31'b0, vld_out}, 32'd0);

        conv("half",    32'h3F000000, 32'd0, 1'b0, 1'b0);
        conv("p75",     32'h3F400000, 32'd1, 1'b0, 1'b0);
        conv("denorm",  32'h00400000, 32'd0, 1'b0, 1'b0);
        conv("negzero", 32'h80000000, 32'd0, 1'b0, 1'b0);
        conv("p2_31",   32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        conv("n2_31",   32'hCF000000, 32'h80000000, 1'b0, 1'b0);
        conv("n2_31p",  32'hCF000001, 32'h80000000, 1'b1, 1'b0);
        conv("maxfin",  32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0);
        conv("pinf",    32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0);
        conv("ninf",    32'hFF800000, 32'h80000000, 1'b1, 1'b0);
        conv("nan",     32'h7FC00000, 32'h7FFFFFFF, 1'b0, 1'b1);
        conv("n3p5",    32'hC0600000, 32'hFFFFFFFC, 1'b0, 1'b0);
        conv("p42",     32'h42280000, 32'd42, 1'b0, 1'b0);
        repeat (3) step();
        check("idle.vld", {31'b0, vld_out}, 32'd0);
        check("idle.res", Result, 32'd42);

        vld_in = 1'b1;
        Oprand_A = 32'h41200000;
        step();
        vld_in = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("frz.vld", {31'b0, vld_out}, 32'd0);
            check("frz.res", Result, 32'd42);
        end
        en = 1'b1;
        step();
        check("en.v2", {31'b0, vld_out}, 32'd0);
        step();
        check_out("ten", 32'd10, 1'b0, 1'b0);

        vld_in = 1'b1;
        Oprand_A = 32'h4F000000; step();
        Oprand_A = 32'h7FC00000; step();
        Oprand_A = 32'h41200000; step();
        vld_in = 1'b0;
        check_out("pre_rst", 32'h7FFFFFFF, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("arst.res", Result, 32'd0);
        check("arst.vld", {31'b0, vld_out}, 32'd0);
        check("arst.flags", {30'b0, ovf, invalid}, 32'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst.vld", {31'b0, vld_out}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
